// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / latency-use hazard scoreboard.
// A shift register of in-flight destinations, one slot per stage beyond ID,
// drives registered per-source forward selects for EX and a combinational
// stall for ID when a producer's result is not yet available.
module fwd_hazard_scoreboard #(
    parameter  int NSRC     = 2,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 2,
    parameter  int REG_W    = 5,
    parameter  int CNT_W    = 16,
    localparam int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*REG_W-1:0]  id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]       stall_count
);

    // Latency field only needs to hold LOAD_LAT; ALU results are always 1.
    localparam int LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] LAT_ALU  = LAT_W'(1);

    // Scoreboard slots: index 0 is the instruction in EX.
    logic [DEPTH-1:0]                  sbV;
    logic [DEPTH-1:0][REG_W-1:0]       sbRd;
    logic [DEPTH-1:0][LAT_W-1:0]       sbLat;

    logic [NSRC-1:0][SELW-1:0]         selNext;
    logic [NSRC-1:0][SELW-1:0]         exFwdSelQ;
    logic [NSRC-1:0]                   hazard;
    logic [CNT_W-1:0]                  stallCnt;
    logic                              bubble;

    // One lookup per source operand.
    for (genvar i = 0; i < NSRC; i++) begin : gSrc
        fwdSrcLookup #(
            .DEPTH (DEPTH),
            .REG_W (REG_W),
            .LAT_W (LAT_W),
            .SELW  (SELW)
        ) uLookup (
            .active (id_valid & id_rs_used[i]),
            .rs     (id_rs[i*REG_W +: REG_W]),
            .sbV    (sbV),
            .sbRd   (sbRd),
            .sbLat  (sbLat),
            .sel    (selNext[i]),
            .hazard (hazard[i])
        );
    end

    // A flushed instruction never stalls; hold does not mask the stall.
    assign stall  = id_valid & ~flush & (|hazard);
    assign bubble = flush | stall | ~id_valid;

    assign ex_fwd_sel  = exFwdSelQ;
    assign stall_count = stallCnt;

    // Shift the older slots down the pipe on every non-held edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < DEPTH; k++) begin
                sbV[k]   <= 1'b0;
                sbRd[k]  <= '0;
                sbLat[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                sbV[k]   <= sbV[k-1];
                sbRd[k]  <= sbRd[k-1];
                sbLat[k] <= sbLat[k-1];
            end
        end
    end

    // Slot 0 takes the ID instruction, or a bubble; x0 writes are never tracked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbV[0]    <= 1'b0;
            sbRd[0]   <= '0;
            sbLat[0]  <= '0;
            exFwdSelQ <= '0;
        end else if (!hold) begin
            if (bubble) begin
                sbV[0]    <= 1'b0;
                exFwdSelQ <= '0;
            end else begin
                sbV[0]    <= id_regwrite && (id_rd != '0);
                sbRd[0]   <= id_rd;
                sbLat[0]  <= id_is_load ? LAT_LOAD : LAT_ALU;
                exFwdSelQ <= selNext;
            end
        end
    end

    // Saturating count of cycles in which ID was actually held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (!hold && stall && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// Per-source lookup: youngest matching slot wins; a hazard exists when the
// producer's result will not yet be in the latch the consumer would read.
module fwdSrcLookup #(
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int LAT_W = 2,
    parameter int SELW  = 2
) (
    input  logic                         active,
    input  logic [REG_W-1:0]             rs,
    input  logic [DEPTH-1:0]             sbV,
    input  logic [DEPTH-1:0][REG_W-1:0]  sbRd,
    input  logic [DEPTH-1:0][LAT_W-1:0]  sbLat,
    output logic [SELW-1:0]              sel,
    output logic                         hazard
);

    // Scan oldest to youngest so the lowest matching slot overrides.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (active && (rs != '0) && sbV[k] && (sbRd[k] == rs)) begin
                sel    = SELW'(k + 1);
                hazard = (k + 1) < int'(sbLat[k]);
            end
        end
    end

endmodule
